instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Assembles RISC-V RV32I instruction words from decoded fields and a 32-bit immediate.
- Inverse of the core's immediate generator: packs the immediate into the R/I/S/B/U/J bit layouts.
- Range-checks every immediate and stamps each word with a sequential instruction-memory byte address.
- Sits between the test/boot loader front end and instruction-memory write port; 2-stage valid/ready pipeline.

Parameters:
ADDR_W, 32, width of out_addr
BASE_ADDR, 0, first address emitted after reset
NOP_WORD, 32'h00000013, word substituted for rejected inputs

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input field set valid
in_ready  out  1  encoder can accept input this cycle
in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6-7 illegal
in_opcode  in  7  opcode field, passed through unchanged
in_rd  in  5  rd field
in_rs1  in  5  rs1 field
in_rs2  in  5  rs2 field
in_funct3  in  3  funct3 field
in_funct7  in  7  funct7 field (R only)
in_imm  in  32  signed byte immediate (U: full upper value)
out_valid  out  1  output word valid
out_ready  in  1  sink accepts word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_instr
out_err  out  1  input rejected; out_instr = NOP_WORD

Behaviour:
- Reset (async, rst_n=0): both stage valids=0, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR; in_ready=1 once rst_n=1.
- Handshake: transfer on valid&&ready both sides. Once out_valid=1, out_instr/out_addr/out_err hold stable until accepted.
- Stage 1: register fields, compute err. Stage 2: assemble word, output register.
- Stage advances when next stage empty or its content is leaving this cycle.
- in_ready = !s1_valid || s1 advancing (combinational from out_ready allowed).
- Latency: input accepted at edge N -> out_valid at edge N+2 if unstalled. Full throughput 1 word/cycle.
- Bubble-free: two entries held under stall, then in_ready=0.
- Order preserved; no drop, no duplication.
- Encoding (imm = in_imm):
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Range rules; violation -> err:
  - I/S: -2048..2047
  - B: -4096..4094, imm[0]=0
  - J: -1048576..1048574, imm[0]=0
  - U: imm[11:0]=0
  - R: imm ignored
  - fmt 6/7: always err
- err word: out_instr=NOP_WORD, out_err=1. Still consumes an address slot.
- out_addr: increments by 4 on each output transfer, modulo 2^ADDR_W; wraps from max aligned address to 0, not to BASE_ADDR.
- Reset mid-operation: in-flight words discarded, out_addr back to BASE_ADDR.

Optional Feature:
- Macro: INSTR_ENC_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0].
  - Increments on each transfer with out_err=1.
  - Saturates at 255.
  - Reset 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- I: fmt=1, opcode=0x13, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, out_err=0, out_addr=BASE_ADDR, out_valid 2 cycles after accept.
- Format layouts, back-to-back: S (opcode 0x23, rs1=3, rs2=2, f3=2, imm=-4), then B (opcode 0x63, rs1=rs2=0, f3=0, imm=-8), then U (opcode 0x37, rd=5, imm=0x12345000) -> 0xFE21AE23, 0xFE000CE3, 0x123452B7 on consecutive cycles at BASE_ADDR, +4, +8.
- Errors: I imm=2048; B imm=3; U imm=0x00000800; fmt=7 -> each gives out_instr=0x00000013, out_err=1, address still increments. With macro, err_cnt=4.
- Backpressure: out_ready=0 while streaming 3 inputs -> in_ready=0 after 2 accepted. Release -> 3 words in order, addresses consecutive, none lost or duplicated.
- Reset mid-stream: rst_n=0 with 2 words in flight -> out_valid=0 immediately. After release, next word at BASE_ADDR.
- Wrap: ADDR_W=4, BASE_ADDR=12, 2 words -> addresses 12 then 0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Bus interface for instr_encoder: loader-side field input and
// instruction-memory-side word output, each with its own valid/ready.
// master = loader/sink side that drives the fields, slave = the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction word assembler. Stage 1 registers the decoded fields
// and range-checks the immediate; stage 2 packs the word into its format
// layout and holds it in the output register together with its byte address.
// Rejected inputs leave as NOP_WORD with out_err set and still use an address.
// Optional: define INSTR_ENC_ERR_CNT_EN to add the saturating err_cnt output.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       NOP_WORD  = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef INSTR_ENC_ERR_CNT_EN
  output logic [7:0] err_cnt,
`endif
  instr_encoder_if.slave bus
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // stage 1 holding register
  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;
  logic        s1_err;

  // stage 2 / output register
  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic              out_err_q;
  logic [ADDR_W-1:0] out_addr_q;

  logic               in_err;
  logic signed [31:0] imm_s;
  logic [31:0]        enc_word;
  logic               s1_adv;
  logic               in_ready_c;
  logic               out_xfer;

  assign imm_s = bus.in_imm;

  // stage 1 moves into stage 2 whenever the output register is free or draining
  assign s1_adv     = s1_valid && (!out_valid_q || bus.out_ready);
  assign in_ready_c = !s1_valid || s1_adv;
  assign out_xfer   = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_addr  = out_addr_q;

  // immediate range check on the incoming fields
  always_comb begin
    in_err = 1'b0;
    case (bus.in_fmt)
      FMT_R: in_err = 1'b0;
      FMT_I,
      FMT_S: in_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      FMT_B: in_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.in_imm[0];
      FMT_U: in_err = |bus.in_imm[11:0];
      FMT_J: in_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || bus.in_imm[0];
      default: in_err = 1'b1;
    endcase
  end

  // stage 1: capture fields and the error flag on an input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= '0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
      s1_err    <= 1'b0;
    end else if (in_ready_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_fmt    <= bus.in_fmt;
        s1_opcode <= bus.in_opcode;
        s1_rd     <= bus.in_rd;
        s1_rs1    <= bus.in_rs1;
        s1_rs2    <= bus.in_rs2;
        s1_funct3 <= bus.in_funct3;
        s1_funct7 <= bus.in_funct7;
        s1_imm    <= bus.in_imm;
        s1_err    <= in_err;
      end
    end
  end

  // pack the stage 1 fields into the format's bit layout
  always_comb begin
    enc_word = NOP_WORD;
    case (s1_fmt)
      FMT_R: enc_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I: enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_B: enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                         s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: enc_word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                         s1_rd, s1_opcode};
      default: enc_word = NOP_WORD;
    endcase
    if (s1_err) enc_word = NOP_WORD;
  end

  // stage 2: output register, held stable until the sink takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
    end else if (s1_adv) begin
      out_valid_q <= 1'b1;
      out_instr_q <= enc_word;
      out_err_q   <= s1_err;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // byte address of the word on the output; wraps naturally at 2^ADDR_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr_q <= BASE_ADDR;
    end else if (out_xfer) begin
      out_addr_q <= out_addr_q + ADDR_W'(4);
    end
  end

`ifdef INSTR_ENC_ERR_CNT_EN
  // count rejected words as they leave, holding at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (out_xfer && out_err_q && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reset state, latency, a vector table of
// format layouts and range boundaries, backpressure, mid-stream reset and
// address wrap on a narrow-address instance.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   nerr = 0;
  logic [31:0] exp_addr = 32'd0;
  vec_t vt [0:31];
  vec_t bp [0:2];

  instr_encoder_if #(.ADDR_W(32)) bus ();
  instr_encoder_if #(.ADDR_W(4))  bus2 ();

`ifdef INSTR_ENC_ERR_CNT_EN
  logic [7:0] err_cnt;
  logic [7:0] err_cnt2;
`endif

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'd0), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef INSTR_ENC_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .bus(bus.slave)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12), .NOP_WORD(32'h0000_0013)) dut2 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef INSTR_ENC_ERR_CNT_EN
    .err_cnt(err_cnt2),
`endif
    .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] exp_instr, input logic exp_err);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_instr = exp_instr; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.in_valid  = valid;
    bus.in_fmt    = v.fmt;
    bus.in_opcode = v.op;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_funct3 = v.f3;
    bus.in_funct7 = v.f7;
    bus.in_imm    = v.imm;
  endtask

  // stream vt[0..n-1] with out_ready held high, checking each output word
  task automatic run_vecs(input int n, input string tag);
    int tx = 0;
    int rx = 0;
    int cyc = 0;
    int first_rx = -1;
    int last_rx = -1;
    bus.out_ready = 1'b1;
    while (rx < n && cyc < 200) begin
      if (tx < n) drive(vt[tx], 1'b1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid) begin
        chk($sformatf("%s%0d_instr", tag, rx), bus.out_instr, vt[rx].exp_instr);
        chk($sformatf("%s%0d_err", tag, rx), {31'd0, bus.out_err}, {31'd0, vt[rx].exp_err});
        chk($sformatf("%s%0d_addr", tag, rx), bus.out_addr, exp_addr);
        if (vt[rx].exp_err) nerr++;
        if (first_rx < 0) first_rx = cyc;
        last_rx = cyc;
        exp_addr += 32'd4;
        rx++;
      end
      if (bus.in_valid && bus.in_ready) tx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_count"}, rx, n);
    chk({tag, "_back_to_back"}, last_rx - first_rx, n - 1);
  endtask

  initial begin
    vec_t i5;
    int acc;
    int rx;
    int c;

    drive(mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0), 1'b0);
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_fmt = 3'd1; bus2.in_opcode = 7'h13; bus2.in_rd = 5'd1;
    bus2.in_rs1 = 5'd0; bus2.in_rs2 = 5'd0; bus2.in_funct3 = 3'd0; bus2.in_funct7 = 7'd0;
    bus2.in_imm = 32'd0; bus2.out_ready = 1'b0;

    vt[0]  = mk(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE21_AE23, 1'b0);
    vt[1]  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE00_0CE3, 1'b0);
    vt[2]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    vt[3]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
    vt[4]  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0013, 1'b1);
    vt[5]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
    vt[6]  = mk(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0013, 1'b1);
    vt[7]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0);
    vt[8]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    vt[9]  = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
    vt[10] = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0000_0013, 1'b1);
    vt[11] = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0801, 32'h0000_0013, 1'b1);
    vt[12] = mk(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
    vt[13] = mk(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF, 32'h7FF0_0013, 1'b0);
    vt[14] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0);
    vt[15] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 32'h8000_0063, 1'b0);
    vt[16] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_0013, 1'b1);
    vt[17] = mk(3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF, 32'h7E00_0FA3, 1'b0);
    vt[18] = mk(3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1);
    vt[19] = mk(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0013, 1'b1);

    i5    = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    bp[0] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
    bp[1] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0093, 1'b0);
    bp[2] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0093, 1'b0);

    // reset state
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef INSTR_ENC_ERR_CNT_EN
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif

    // single I word: one empty cycle after the accepting edge, then valid
    @(posedge clk); #1;
    drive(i5, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_instr", bus.out_instr, 32'h0050_0093);
    chk("lat_err", {31'd0, bus.out_err}, 32'd0);
    chk("lat_addr", bus.out_addr, 32'd0);
    exp_addr = 32'd4;
    @(posedge clk); #1;

    // format layouts, range boundaries and rejects, back to back
    run_vecs(20, "tbl");
`ifdef INSTR_ENC_ERR_CNT_EN
    chk("err_cnt_after_table", {24'd0, err_cnt}, nerr);
`endif

    // backpressure: sink stalls for 8 cycles while 3 words are offered
    acc = 0;
    rx = 0;
    c = 0;
    while (c < 40 && rx < 3) begin
      bus.out_ready = (c >= 8);
      if (acc < 3) drive(bp[acc], 1'b1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (c == 7) begin
        chk("bp_accepted_under_stall", acc, 32'd2);
        chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_held_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_held_instr", bus.out_instr, bp[0].exp_instr);
        chk("bp_held_addr", bus.out_addr, exp_addr);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp%0d_instr", rx), bus.out_instr, bp[rx].exp_instr);
        chk($sformatf("bp%0d_addr", rx), bus.out_addr, exp_addr);
        exp_addr += 32'd4;
        rx++;
      end
      if (bus.in_valid && bus.in_ready) acc++;
      @(posedge clk); #1;
      c++;
    end
    bus.in_valid = 1'b0;
    chk("bp_received", rx, 32'd3);
    chk("bp_accepted", acc, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_no_duplicate", {31'd0, bus.out_valid}, 32'd0);

    // reset with two words in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      if (acc < 2) drive(bp[acc], 1'b1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_accepted", acc, 32'd2);
    chk("mid_valid_before_reset", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_reset_addr", bus.out_addr, 32'd0);
`ifdef INSTR_ENC_ERR_CNT_EN
    chk("mid_reset_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = 32'd0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_reset_empty", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    vt[0] = mk(3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_8113, 1'b0);
    run_vecs(1, "post_rst");

    // narrow address space: 12 then wrap to 0
    rx = 0;
    acc = 0;
    bus2.out_ready = 1'b1;
    for (int k = 0; k < 10 && rx < 2; k++) begin
      bus2.in_valid = (acc < 2);
      bus2.in_imm = (acc == 0) ? 32'd1 : 32'd2;
      @(negedge clk);
      if (bus2.out_valid) begin
        chk($sformatf("wrap%0d_addr", rx), {28'd0, bus2.out_addr}, (rx == 0) ? 32'd12 : 32'd0);
        chk($sformatf("wrap%0d_instr", rx), bus2.out_instr,
            (rx == 0) ? 32'h0010_0093 : 32'h0020_0093);
        rx++;
      end
      if (bus2.in_valid && bus2.in_ready) acc++;
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    chk("wrap_received", rx, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
